// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and transmitter state encoding for the UART path
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  localparam int DEFAULT_CLKS_PER_BIT = 217;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with a registered occupancy count
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_L,
  input  logic                   i_Push,
  input  logic                   i_Pop,
  input  logic [WIDTH-1:0]       i_Data,
  output logic [WIDTH-1:0]       o_Data,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Full,
  output logic                   o_Empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign o_Full = count_q == (AW+1)'(DEPTH);
  assign o_Empty = count_q == '0;
  assign o_Count = count_q;
  assign o_Data = mem_q[rd_ptr_q];
  assign push_ok = i_Push && !o_Full;
  assign pop_ok = i_Pop && !o_Empty;
  // Next storage, pointers and occupancy; a push into a full queue is ignored
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = i_Data;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  // Storage is not reset; the count alone says which entries are valid
  always_ff @(posedge i_Clock) mem_q <= mem_d;
  // Pointers and count clear on reset, which empties the queue
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queued UART transmitter with configurable width, parity and stop bits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_L,
  input  logic                        i_TX_DV,
  input  logic [DATA_BITS-1:0]        i_TX_Byte,
  output logic                        o_TX_Ready,
  output logic                        o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count,
  output logic                        o_TX_Active,
  output logic                        o_TX_Serial,
  output logic                        o_TX_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT * 2);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic HAS_PARITY = PARITY_MODE != PARITY_NONE;
  localparam logic ODD_FLIP = PARITY_MODE == PARITY_ODD;
  tx_state_e state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic parity_q, parity_d;
  logic serial_q, serial_d;
  logic active_q, active_d;
  logic done_q, done_d;
  logic overflow_q, overflow_d;
  logic fifo_pop, fifo_full, fifo_empty, bit_end;
  logic [DATA_BITS-1:0] fifo_data;
  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_Clock(i_Clock),
    .i_Rst_L(i_Rst_L),
    .i_Push (i_TX_DV),
    .i_Pop  (fifo_pop),
    .i_Data (i_TX_Byte),
    .o_Data (fifo_data),
    .o_Count(o_FIFO_Count),
    .o_Full (fifo_full),
    .o_Empty(fifo_empty)
  );
  assign bit_end = clk_cnt_q == BIT_END;
  assign o_TX_Ready = !fifo_full;
  assign o_TX_Serial = serial_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done = done_q;
  assign o_Overflow = overflow_q;
  // Frame sequencing; line outputs are registered copies of the current state
  always_comb begin
    state_d = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    parity_d = parity_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d = fifo_data;
          parity_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d = shift_q >> 1;
          parity_d = parity_q ^ shift_q[0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d = HAS_PARITY ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (clk_cnt_q == STOP_END) begin
          clk_cnt_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    serial_d = state_q == START ? 1'b0 :
               state_q == DATA ? shift_q[0] :
               state_q == PARITY ? parity_q ^ ODD_FLIP : 1'b1;
    active_d = state_q != IDLE;
    done_d = state_q == STOP && clk_cnt_q == STOP_END;
    overflow_d = i_TX_DV && fifo_full;
  end
  // State and output registers; reset aborts any frame and idles the line high
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q <= done_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench decoding the serial line of four configurations
module tb_uart_tx_fifo;
  localparam int CLK = 4;
  function automatic int db_of(input int k);
    return k == 3 ? 7 : 8;
  endfunction
  function automatic int par_of(input int k);
    return (k == 1 || k == 2) ? k : 0;
  endfunction
  function automatic int sb_of(input int k);
    return k == 3 ? 2 : 1;
  endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dv [4];
  logic [8:0] byte_v [4];
  logic rdy [4];
  logic ovf [4];
  logic [2:0] cnt [4];
  logic act [4];
  logic ser [4];
  logic done [4];
  logic [8:0] exp_q [$];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DB = db_of(g);
    uart_tx_fifo #(
      .CLKS_PER_BIT(CLK),
      .DATA_BITS   (DB),
      .PARITY_MODE (par_of(g)),
      .STOP_BITS   (sb_of(g)),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .i_Clock     (clk),
      .i_Rst_L     (rst_n),
      .i_TX_DV     (dv[g]),
      .i_TX_Byte   (byte_v[g][DB-1:0]),
      .o_TX_Ready  (rdy[g]),
      .o_Overflow  (ovf[g]),
      .o_FIFO_Count(cnt[g]),
      .o_TX_Active (act[g]),
      .o_TX_Serial (ser[g]),
      .o_TX_Done   (done[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int k, input logic [8:0] d, input logic track);
    dv[k] = 1'b1;
    byte_v[k] = d;
    tick();
    dv[k] = 1'b0;
    if (track) exp_q.push_back(d & 9'((1 << db_of(k)) - 1));
  endtask
  task automatic rx_frame(input int k, output int n);
    int db, p, len, s, bad_start, bad_stop, unstable, act_n, done_n, done_at;
    logic sv [64];
    logic av [64];
    logic ds [64];
    logic [8:0] got, expv;
    logic ep;
    db = db_of(k);
    p = par_of(k) != 0 ? 1 : 0;
    len = (1 + db + p + sb_of(k)) * CLK;
    n = 0;
    while (ser[k] !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check("start_seen", ser[k], 0);
    if (ser[k] !== 1'b0) return;
    for (int i = 0; i <= len; i++) begin
      if (i > 0) tick();
      sv[i] = ser[k];
      av[i] = act[k];
      ds[i] = done[k];
    end
    got = '0;
    bad_start = 0;
    bad_stop = 0;
    unstable = 0;
    act_n = 0;
    done_n = 0;
    done_at = -1;
    for (int i = 0; i < len; i++) begin
      s = i / CLK;
      if (av[i] === 1'b1) act_n++;
      if (ds[i] === 1'b1) begin
        done_n++;
        done_at = i;
      end
      if (sv[i] !== sv[s*CLK]) unstable++;
      if (s == 0 && sv[i] !== 1'b0) bad_start++;
      if (s > db + p && sv[i] !== 1'b1) bad_stop++;
    end
    for (int b = 0; b < db; b++) got[b] = sv[(1+b)*CLK + CLK/2];
    check("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    expv = exp_q.pop_front();
    ep = par_of(k) == 2;
    for (int b = 0; b < db; b++) ep ^= expv[b];
    check("start_bit", bad_start, 0);
    check("bit_stable", unstable, 0);
    check("data", got, expv);
    if (p != 0) check("parity", sv[(1+db)*CLK + CLK/2], ep);
    check("stop_bits", bad_stop, 0);
    check("active_len", act_n, len);
    check("done_cnt", done_n, 1);
    check("done_at", done_at, len - 1);
    check("tail", {sv[len], av[len], ds[len]}, 3'b100);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, w, hits, lows;
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0;
      byte_v[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      check("rst_ser", ser[k], 1);
      check("rst_act", act[k], 0);
      check("rst_done", done[k], 0);
      check("rst_ovf", ovf[k], 0);
      check("rst_cnt", cnt[k], 0);
      check("rst_rdy", rdy[k], 1);
    end
    rst_n = 1'b1;
    tick();
    // 8N1 single frame, latency from push edge
    push(0, 9'h3F, 1'b1);
    check("cnt_after_push", cnt[0], 1);
    rx_frame(0, n);
    check("latency", n, 2);
    // even then odd parity
    push(1, 9'h37, 1'b1);
    rx_frame(1, n);
    check("latency_even", n, 2);
    push(2, 9'h37, 1'b1);
    rx_frame(2, n);
    check("latency_odd", n, 2);
    // seven data bits, two stop bits
    push(3, 9'h55, 1'b1);
    rx_frame(3, n);
    check("latency_7n2", n, 2);
    repeat (5) tick();
    // burst into the queue, overflow and back-to-back frames
    fork
      begin
        for (int i = 1; i <= 5; i++) push(0, 9'(i), 1'b1);
        check("full_cnt", cnt[0], 4);
        check("full_rdy", rdy[0], 0);
        dv[0] = 1'b1;
        byte_v[0] = 9'h06;
        tick();
        dv[0] = 1'b0;
        check("ovf_pulse", ovf[0], 1);
        check("ovf_cnt", cnt[0], 4);
        tick();
        check("ovf_clear", ovf[0], 0);
      end
      begin
        rx_frame(0, n);
        check("burst_latency", n, 3);
        for (int i = 0; i < 4; i++) begin
          rx_frame(0, n);
          check("gap", n, 1);
        end
      end
    join
    check("drained_cnt", cnt[0], 0);
    check("drained_rdy", rdy[0], 1);
    repeat (5) tick();
    // push while full on the same edge the transmitter pops
    fork
      begin
        for (int i = 0; i < 5; i++) push(0, 9'hA0 + 9'(i), 1'b1);
        w = 0;
        while (done[0] !== 1'b1 && w < 200) begin
          tick();
          w++;
        end
        check("done_seen", done[0], 1);
        dv[0] = 1'b1;
        byte_v[0] = 9'hEE;
        tick();
        dv[0] = 1'b0;
        check("pop_ovf", ovf[0], 1);
        check("pop_ovf_cnt", cnt[0], 3);
      end
      begin
        rx_frame(0, n);
        for (int i = 0; i < 4; i++) begin
          rx_frame(0, n);
          check("gap2", n, 1);
        end
      end
    join
    repeat (5) tick();
    // reset mid-DATA with two characters queued
    push(0, 9'hB0, 1'b0);
    push(0, 9'hB1, 1'b0);
    push(0, 9'hB2, 1'b0);
    check("pre_rst_cnt", cnt[0], 2);
    repeat (14) tick();
    check("pre_rst_act", act[0], 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ser", ser[0], 1);
    check("abort_act", act[0], 0);
    check("abort_cnt", cnt[0], 0);
    check("abort_rdy", rdy[0], 1);
    hits = 0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done[0] !== 1'b0) hits++;
      if (ser[0] !== 1'b1) lows++;
    end
    check("abort_no_done", hits, 0);
    check("abort_quiet", lows, 0);
    push(0, 9'hC3, 1'b1);
    rx_frame(0, n);
    check("post_rst_latency", n, 2);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
